// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and a ready/clear handshake.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 clken,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [1:0]           r_rxSync;
    logic [2:0]           r_state;
    logic [3:0]           r_sample;
    logic [2:0]           r_bitpos;
    logic [DATA_BITS-1:0] r_scratch;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_rdy;
    logic                 r_frameErr;
    logic                 r_overrun;

    logic w_rxS;
    logic w_bitEnd;
    logic w_stopTick;
    logic w_parityOk;
    logic w_frameGood;
    logic w_frameBad;

    // The synchronizer idles high so a reset never looks like a start bit.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_rxSync <= 2'b11;
        end else begin
            r_rxSync <= {r_rxSync[0], rx};
        end
    end

    assign w_rxS      = r_rxSync[1];
    assign w_bitEnd   = (r_sample == 4'd15);
    assign w_stopTick = clken && (r_state == S_STOP) && w_bitEnd;

`ifdef UART_RX_PARITY_EN
    logic r_parityErr;
    assign w_parityOk = !r_parityErr;
`else
    assign w_parityOk = 1'b1;
`endif

    assign w_frameGood = w_stopTick && w_rxS && w_parityOk;
    assign w_frameBad  = w_stopTick && !w_frameGood;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sample  <= 4'd0;
            r_bitpos  <= 3'd0;
            r_scratch <= '0;
`ifdef UART_RX_PARITY_EN
            r_parityErr <= 1'b0;
`endif
        end else if (clken) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxS) begin
                        r_sample <= 4'd0;
                        r_bitpos <= 3'd0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    // Recheck at mid start bit; a line that is high again was only a glitch.
                    if (r_sample == 4'd7) begin
                        r_sample <= 4'd0;
                        r_state  <= w_rxS ? S_IDLE : S_DATA;
                    end else begin
                        r_sample <= r_sample + 4'd1;
                    end
                end
                S_DATA: begin
                    r_sample <= r_sample + 4'd1;
                    if (w_bitEnd) begin
                        r_scratch[r_bitpos] <= w_rxS;
                        r_bitpos            <= r_bitpos + 3'd1;
                        if (r_bitpos == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    r_sample <= r_sample + 4'd1;
                    if (w_bitEnd) begin
                        r_parityErr <= (^r_scratch) ^ w_rxS;
                        r_state     <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    r_sample <= r_sample + 4'd1;
                    if (w_bitEnd) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A completing byte takes priority over a simultaneous host clear.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_data     <= '0;
            r_rdy      <= 1'b0;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (rdy_clr) begin
                r_rdy     <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_frameGood) begin
                r_data     <= r_scratch;
                r_rdy      <= 1'b1;
                r_frameErr <= 1'b0;
                if (r_rdy && !rdy_clr) begin
                    r_overrun <= 1'b1;
                end
            end
            if (w_frameBad) begin
                r_frameErr <= 1'b1;
            end
        end
    end

    assign data      = r_data;
    assign rdy       = r_rdy;
    assign frame_err = r_frameErr;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: idle, latency, glitch, framing, overrun, reset.
// clken pulses every 4 clocks, so one bit lasts 16 ticks = 64 clocks.
module tb_uart_rx;

    logic       clk_50m = 1'b0;
    logic       rst     = 1'b1;
    logic       clken   = 1'b0;
    logic       rx      = 1'b1;
    logic       rdy_clr = 1'b0;
    logic [7:0] data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;

    int         assertCount = 0;
    int         failCount   = 0;
    logic [1:0] tickDiv     = 2'd0;

    uart_rx #(.DATA_BITS(8)) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .clken     (clken),
        .rx        (rx),
        .rdy_clr   (rdy_clr),
        .data      (data),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #10 clk_50m = ~clk_50m;

    always @(negedge clk_50m) begin
        tickDiv = tickDiv + 2'd1;
        clken   = (tickDiv == 2'd0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitTicks(input int n);
        repeat (4 * n) @(negedge clk_50m);
    endtask

    // Start bit, data LSB first and, when enabled, a correct even-parity bit.
    task automatic driveBits(input logic [7:0] value);
        rx = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 8; i++) begin
            rx = value[i];
            waitTicks(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^value;
        waitTicks(16);
`endif
    endtask

    task automatic applyStimulus(input logic [7:0] value, input logic stopBit);
        driveBits(value);
        rx = stopBit;
        waitTicks(16);
        rx = 1'b1;
        waitTicks(8);
    endtask

    task automatic pulseClear();
        @(negedge clk_50m);
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
    endtask

    initial begin
        $display("[TB] uart_rx directed test starting");
        rst = 1'b1;
        repeat (4) @(negedge clk_50m);
        rst = 1'b0;
        checkOutput("reset rdy",       32'(rdy),       32'd0);
        checkOutput("reset frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset overrun",   32'(overrun),   32'd0);
        checkOutput("reset data",      32'(data),      32'h00);

        waitTicks(200);
        checkOutput("idle rdy",       32'(rdy),       32'd0);
        checkOutput("idle frame_err", 32'(frame_err), 32'd0);
        checkOutput("idle overrun",   32'(overrun),   32'd0);
        checkOutput("idle data",      32'(data),      32'h00);

        // Stop bit is sampled 8..9.5 ticks into the stop bit given sync and tick phase.
        driveBits(8'hA5);
        rx = 1'b1;
        waitTicks(6);
        checkOutput("A5 rdy before stop sample", 32'(rdy), 32'd0);
        waitTicks(5);
        checkOutput("A5 rdy after stop sample", 32'(rdy),       32'd1);
        checkOutput("A5 data",                  32'(data),      32'hA5);
        checkOutput("A5 frame_err",             32'(frame_err), 32'd0);
        waitTicks(13);
        pulseClear();
        checkOutput("A5 rdy cleared", 32'(rdy), 32'd0);

        rx = 1'b0;
        waitTicks(4);
        rx = 1'b1;
        waitTicks(20);
        checkOutput("glitch rdy",       32'(rdy),       32'd0);
        checkOutput("glitch frame_err", 32'(frame_err), 32'd0);
        applyStimulus(8'h3C, 1'b1);
        checkOutput("3C data", 32'(data), 32'h3C);
        checkOutput("3C rdy",  32'(rdy),  32'd1);
        pulseClear();

        applyStimulus(8'h55, 1'b0);
        checkOutput("bad stop frame_err", 32'(frame_err), 32'd1);
        checkOutput("bad stop rdy",       32'(rdy),       32'd0);
        checkOutput("bad stop data kept", 32'(data),      32'h3C);
        applyStimulus(8'h0F, 1'b1);
        checkOutput("0F data",      32'(data),      32'h0F);
        checkOutput("0F frame_err", 32'(frame_err), 32'd0);
        checkOutput("0F rdy",       32'(rdy),       32'd1);
        pulseClear();

        applyStimulus(8'h11, 1'b1);
        checkOutput("11 rdy",     32'(rdy),     32'd1);
        checkOutput("11 overrun", 32'(overrun), 32'd0);
        applyStimulus(8'h22, 1'b1);
        checkOutput("22 data",    32'(data),    32'h22);
        checkOutput("22 rdy",     32'(rdy),     32'd1);
        checkOutput("22 overrun", 32'(overrun), 32'd1);
        pulseClear();
        checkOutput("clear rdy",     32'(rdy),     32'd0);
        checkOutput("clear overrun", 32'(overrun), 32'd0);

        // Reset lands 60 ticks into an all-ones frame.
        rx = 1'b0;
        waitTicks(16);
        rx = 1'b1;
        waitTicks(44);
        rst = 1'b1;
        repeat (2) @(negedge clk_50m);
        rst = 1'b0;
        checkOutput("midframe reset rdy",       32'(rdy),       32'd0);
        checkOutput("midframe reset frame_err", 32'(frame_err), 32'd0);
        checkOutput("midframe reset data",      32'(data),      32'h00);
        waitTicks(120);
        applyStimulus(8'h81, 1'b1);
        checkOutput("81 data",      32'(data),      32'h81);
        checkOutput("81 frame_err", 32'(frame_err), 32'd0);
        checkOutput("81 rdy",       32'(rdy),       32'd1);
        pulseClear();

`ifdef UART_RX_PARITY_EN
        rx = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 8; i++) begin
            rx = (i == 0 || i == 7);
            waitTicks(16);
        end
        rx = 1'b1;
        waitTicks(16);
        rx = 1'b1;
        waitTicks(24);
        checkOutput("bad parity frame_err", 32'(frame_err), 32'd1);
        checkOutput("bad parity rdy",       32'(rdy),       32'd0);
        checkOutput("bad parity data kept", 32'(data),      32'h81);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises an asynchronous 8N1 serial line into parallel bytes, using the 16x-oversampling `rxclk_en` strobe from the design's baud rate generator. It is the receive-side counterpart to the UART transmitter, and both are clocked from the same 50 MHz domain. A synchronizer, a mid-bit sampling state machine and a ready/clear handshake hand each byte to the host logic.

## Interface
- `DATA_BITS`, 8, number of data bits per frame, legal 5..8, LSB first.
- `clk_50m`  input  1  system clock, all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `clken`  input  1  oversample strobe, one `clk_50m` cycle wide, 16 per bit period; driven from `rxclk_en`.
- `rx`  input  1  asynchronous serial line; idles high.
- `rdy_clr`  input  1  host acknowledge; clears `rdy`.
- `data`  output  DATA_BITS  last good received byte, zero-extended to the low bits.
- `rdy`  output  1  byte available in `data`.
- `frame_err`  output  1  last frame had a bad stop bit (or bad parity, see Configuration).
- `overrun`  output  1  a byte completed while `rdy` was still set. Sticky.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value `rx_s`.
- State is held only in the FSM state, the 4-bit `sample` counter, the 3-bit `bitpos` counter and the shift register `scratch`. Counters advance only on `clken`.
- IDLE:
  - On a `clken` tick with `rx_s`=0, clear `sample` and `bitpos`, then go to START.
- START:
  - `sample` increments on each tick.
  - On the tick where `sample`==7 (mid start bit), check `rx_s`.
  - If `rx_s`=0: clear `sample` and go to DATA.
  - If `rx_s`=1: treat as a glitch and return to IDLE. No flags change.
- DATA:
  - `sample` increments on each tick and wraps 15→0.
  - On the tick where `sample`==15, do `scratch[bitpos]`←`rx_s` and `bitpos`++.
  - After sampling bit DATA_BITS−1, go to STOP (or PARITY).
- STOP, on the tick where `sample`==15:
  - `rx_s`=1: `data`←`scratch`, `rdy`←1, `frame_err`←0. If `rdy` was already 1 and `rdy_clr` is not asserted in this cycle, `overrun`←1.
  - `rx_s`=0: `frame_err`←1. `data` and `rdy` are unchanged.
  - Either way, go to IDLE. A held-low line (break) re-enters START immediately and repeats `frame_err`.
- Handshake:
  - `rdy_clr`=1 clears `rdy` and `overrun` on the next edge.
  - If `rdy_clr` coincides with a byte completing, the set wins: `rdy`=1 and `overrun`=0.
- `clken` low: the FSM holds all state indefinitely.
- Reset values: state IDLE, `data`=0, `rdy`=0, `frame_err`=0, `overrun`=0, `scratch`=0, counters 0, synchronizer flops 1.
- Reset asserted mid-frame: the partial byte is discarded and the FSM resumes in IDLE.

## Timing
- Synchronizer latency: 2 `clk_50m` cycles.
- Mid-bit sampling points: 8, 24, 40, … ticks after the first low tick, at ±1 tick resolution.
- `rdy` rises 1 `clk_50m` cycle after the `clken` edge that samples the stop bit.
- Start-edge-to-`rdy` latency (8N1): 2 cycles + 8 + 16·(DATA_BITS+1) ticks = 152 ticks at 8 bits.
- No back-to-back gap is required. A new start bit is accepted on the tick after STOP completes.
- `rdy_clr` is honoured in any state and does not disturb an in-progress frame.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It samples one bit at `sample`==15 and checks even parity over data plus parity bit.
  - On a mismatch, STOP does not set `rdy` and sets `frame_err`=1, even if the stop bit is good.
  - Latency grows by 16 ticks.
- Undefined: no PARITY state, frame is 8N1.

## Test plan
- Reset, then `rx`=1 for 200 ticks -> `rdy`=0, `frame_err`=0, `overrun`=0, `data`=0x00.
- Send 0xA5, 8N1, 16 ticks/bit -> `rdy`=1 with `data`=0xA5 after 152 ticks. Then pulse `rdy_clr` -> `rdy`=0 on the next cycle.
- Low glitch on `rx` of 4 ticks -> FSM returns to IDLE, `rdy` stays 0, and a following 0x3C is received correctly.
- Send 0x55 with stop bit 0 -> `frame_err`=1, `rdy`=0, `data` keeps its prior value. Then send good 0x0F -> `data`=0x0F, `frame_err`=0.
- Send 0x11 then 0x22 with no `rdy_clr` -> `data`=0x22, `overrun`=1. Then `rdy_clr` -> `rdy`=0, `overrun`=0.
- Assert `rst` at tick 60 of a 0xFF frame, then send 0x81 -> `data`=0x81 with no `frame_err`. With `UART_RX_PARITY_EN`, 0x81 with parity bit 1 -> `frame_err`=1, `rdy`=0.
